// File: rtl/pipelined_barrel_shifter.sv
// Log-depth barrel shifter/rotator (SLL, SRL, SRA, ROL, ROR) split over STAGES register
// stages with valid/ready on both sides and full backpressure.
module pipelined_barrel_shifter #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STAGES  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [2:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_carry,
    output logic               out_illegal,
    output logic               busy
);

    typedef enum logic [2:0] {
        OP_SLL = 3'd0,
        OP_SRL = 3'd1,
        OP_SRA = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } op_e;

    // Handshake: a beat moves on valid && ready at a rising clock edge. Stage k loads
    // whenever it is empty or the stage after it (or the output port) takes its beat.

    // Layers are spread evenly; the last (SHAMT_W % STAGES) stages take one extra.
    function automatic int f_layers(input int k);
        return (SHAMT_W / STAGES) + ((k >= STAGES - (SHAMT_W % STAGES)) ? 1 : 0);
    endfunction

    function automatic int f_first(input int k);
        int s;
        s = 0;
        for (int i = 0; i < k; i++) s += f_layers(i);
        return s;
    endfunction

    function automatic logic [WIDTH-1:0] f_layer(input logic [WIDTH-1:0] d,
                                                 input logic [2:0]       op,
                                                 input int               amt);
        logic [WIDTH-1:0] r;
        case (op)
            OP_SLL:  r = d << amt;
            OP_SRL:  r = d >> amt;
            OP_SRA:  r = $signed(d) >>> amt;
            OP_ROL:  r = (d << amt) | (d >> (WIDTH - amt));
            OP_ROR:  r = (d >> amt) | (d << (WIDTH - amt));
            default: r = d;
        endcase
        return r;
    endfunction

    logic [STAGES-1:0]  w_valid;
    logic [STAGES-1:0]  w_empty;
    logic [STAGES-1:0]  w_adv;
    logic [SHAMT_W-1:0] w_shamt_m1;
    logic [WIDTH-1:0]   w_sll_probe;
    logic [WIDTH-1:0]   w_srl_probe;
    logic               w_in_carry;

    // The last bit shifted out is found from the original operand, so it is resolved
    // once at the input and then travels with the beat.
    assign w_shamt_m1  = in_shamt - SHAMT_W'(1);
    assign w_sll_probe = in_data << w_shamt_m1;
    assign w_srl_probe = in_data >> w_shamt_m1;

    always_comb begin
        w_in_carry = 1'b0;
        if (in_shamt != '0) begin
            case (in_op)
                OP_SLL:         w_in_carry = w_sll_probe[WIDTH-1];
                OP_SRL, OP_SRA: w_in_carry = w_srl_probe[0];
                default:        w_in_carry = 1'b0;
            endcase
        end
    end

    assign w_empty = ~w_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_adv
        assign w_adv[k] = out_ready || (|w_empty[STAGES-1:k]);
    end

    assign in_ready = w_adv[0];
    assign busy     = |w_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = f_first(k);
        localparam int NL = f_layers(k);

        logic               w_src_valid;
        logic [WIDTH-1:0]   w_src_data;
        logic [SHAMT_W-1:0] w_src_shamt;
        logic [2:0]         w_src_op;
        logic               w_src_carry;
        logic [WIDTH-1:0]   w_shifted;

        logic               r_valid;
        logic [WIDTH-1:0]   r_data;
        logic [2:0]         r_op;
        logic               r_carry;

        if (k == 0) begin : g_src
            assign w_src_valid = in_valid;
            assign w_src_data  = in_data;
            assign w_src_shamt = in_shamt;
            assign w_src_op    = in_op;
            assign w_src_carry = w_in_carry;
        end else begin : g_src
            assign w_src_valid = g_stage[k-1].r_valid;
            assign w_src_data  = g_stage[k-1].r_data;
            assign w_src_shamt = g_stage[k-1].g_keep.r_shamt;
            assign w_src_op    = g_stage[k-1].r_op;
            assign w_src_carry = g_stage[k-1].r_carry;
        end

        always_comb begin
            w_shifted = w_src_data;
            for (int j = LO; j < LO + NL; j++) begin
                if (((w_src_shamt >> j) & SHAMT_W'(1)) != '0)
                    w_shifted = f_layer(w_shifted, w_src_op, 1 << j);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_data  <= '0;
                r_op    <= '0;
                r_carry <= 1'b0;
            end else if (w_adv[k]) begin
                r_valid <= w_src_valid;
                if (w_src_valid) begin
                    r_data  <= w_shifted;
                    r_op    <= w_src_op;
                    r_carry <= w_src_carry;
                end
            end
        end

        // Only stages that feed another stage need to keep the shift amount.
        if (k < STAGES - 1) begin : g_keep
            logic [SHAMT_W-1:0] r_shamt;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_shamt <= '0;
                else if (w_adv[k] && w_src_valid)
                    r_shamt <= w_src_shamt;
            end
        end

        assign w_valid[k] = r_valid;
    end

    assign out_valid   = g_stage[STAGES-1].r_valid;
    assign out_data    = g_stage[STAGES-1].r_data;
    assign out_carry   = g_stage[STAGES-1].r_carry;
    assign out_illegal = (g_stage[STAGES-1].r_op > 3'd4);

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: directed corner cases, backpressure, reset and
// random traffic, all checked by a queue-based scoreboard against an arithmetic model.
module tb_pipelined_barrel_shifter;

    localparam int WIDTH   = 16;
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int STAGES  = 2;
    localparam int EW      = WIDTH + 2;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [2:0]         in_op;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_carry;
    logic               out_illegal;
    logic               busy;

    pipelined_barrel_shifter #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_shamt    (in_shamt),
        .in_op       (in_op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_carry   (out_carry),
        .out_illegal (out_illegal),
        .busy        (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, required finish within time limit");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    logic [EW-1:0]      exp_q[$];   // {illegal, carry, data}
    int                 n_cmp;
    int                 n_err;
    int                 n_out;

    logic               pend;
    logic [WIDTH-1:0]   p_data;
    logic [SHAMT_W-1:0] p_shamt;
    logic [2:0]         p_op;
    logic [EW-1:0]      p_exp;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operand value.
    function automatic logic [EW-1:0] ref_model(input logic [WIDTH-1:0] d, input int s,
                                               input int op);
        longint m, x, p, xs, q, r;
        logic [63:0] rv;
        logic c;
        m = longint'(1) << WIDTH;
        x = longint'(d);
        p = longint'(1) << s;
        c = 1'b0;
        r = x;
        case (op)
            0: begin
                r = (x * p) % m;
                if (s > 0) c = (((x * p) / m) % 2) == 1;
            end
            1: begin
                r = x / p;
                if (s > 0) c = ((x / (p / 2)) % 2) == 1;
            end
            2: begin
                xs = (x >= m / 2) ? x - m : x;
                q  = xs / p;
                if ((xs % p) != 0 && xs < 0) q = q - 1;
                r  = (q < 0) ? q + m : q;
                if (s > 0) c = ((x / (p / 2)) % 2) == 1;
            end
            3: r = (x * p) % m + (x * p) / m;
            4: begin
                p = longint'(1) << ((WIDTH - s) % WIDTH);
                r = (x * p) % m + (x * p) / m;
            end
            default: r = x;
        endcase
        rv = r;
        return {op > 4, c, rv[WIDTH-1:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic load_exp(input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] s,
                            input logic [2:0] op, input logic ill, input logic c,
                            input logic [WIDTH-1:0] res);
        pend    = 1'b1;
        p_data  = d;
        p_shamt = s;
        p_op    = op;
        p_exp   = {ill, c, res};
    endtask

    task automatic load_model(input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] s,
                              input logic [2:0] op);
        pend    = 1'b1;
        p_data  = d;
        p_shamt = s;
        p_op    = op;
        p_exp   = ref_model(d, int'(s), int'(op));
    endtask

    task automatic load_rand();
        load_model(WIDTH'($urandom()), SHAMT_W'($urandom_range(0, WIDTH - 1)),
                   3'($urandom_range(0, 7)));
    endtask

    // One cycle: drive after the falling edge, sample 1 time unit before the rising edge.
    task automatic step(input logic ordy, output logic acc);
        @(negedge clk);
        out_ready = ordy;
        in_valid  = pend;
        in_data   = p_data;
        in_shamt  = p_shamt;
        in_op     = p_op;
        #4;
        acc = in_valid && in_ready;
        if (acc) begin
            exp_q.push_back(p_exp);
            pend = 1'b0;
        end
    endtask

    task automatic send_pending(input logic ordy);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 200 && !acc; t++) step(ordy, acc);
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got no acceptance, required one within 200 cycles");
        end
    endtask

    task automatic drain();
        logic acc;
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) step(1'b1, acc);
        step(1'b1, acc);
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    // ---------------- monitor ----------------
    initial begin
        n_out = 0;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL out_unexpected: got beat data 0x%0h, expected no beat", out_data);
                end else begin
                    check("out_beat", 64'({out_illegal, out_carry, out_data}), 64'(exp_q[0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic acc;
        int   n_acc;
        int   n_seen;
        int   idx;

        n_cmp     = 0;
        n_err     = 0;
        pend      = 1'b0;
        p_data    = '0;
        p_shamt   = '0;
        p_op      = '0;
        p_exp     = '0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = '0;
        out_ready = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_carry", 64'(out_carry), 64'(0));
        check("rst_out_illegal", 64'(out_illegal), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, acc);
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // Directed corner cases.
        load_exp(16'h8001, 4'd1,  3'd3, 1'b0, 1'b0, 16'h0003); send_pending(1'b1);
        load_exp(16'h8001, 4'd4,  3'd4, 1'b0, 1'b0, 16'h1800); send_pending(1'b1);
        load_exp(16'h8000, 4'd15, 3'd2, 1'b0, 1'b0, 16'hFFFF); send_pending(1'b1);
        load_exp(16'h8000, 4'd15, 3'd1, 1'b0, 1'b0, 16'h0001); send_pending(1'b1);
        load_exp(16'hC000, 4'd1,  3'd0, 1'b0, 1'b1, 16'h8000); send_pending(1'b1);
        load_exp(16'h0001, 4'd1,  3'd1, 1'b0, 1'b1, 16'h0000); send_pending(1'b1);
        load_exp(16'h0002, 4'd15, 3'd0, 1'b0, 1'b1, 16'h0000); send_pending(1'b1);
        load_exp(16'h4000, 4'd3,  3'd2, 1'b0, 1'b0, 16'h0800); send_pending(1'b1);
        load_exp(16'hF00F, 4'd8,  3'd4, 1'b0, 1'b0, 16'h0FF0); send_pending(1'b1);
        for (int op = 0; op < 5; op++) begin
            load_exp(16'hA5C3, 4'd0, 3'(op), 1'b0, 1'b0, 16'hA5C3);
            send_pending(1'b1);
        end
        load_exp(16'h1234, 4'd5, 3'd7, 1'b1, 1'b0, 16'h1234); send_pending(1'b1);
        drain();
        check("idle_busy", 64'(busy), 64'(0));

        // Latency of a reserved op through an empty pipeline.
        load_exp(16'h1234, 4'd3, 3'd6, 1'b1, 1'b0, 16'h1234);
        send_pending(1'b1);
        for (int k = 1; k <= STAGES + 1; k++) begin
            step(1'b1, acc);
            check("lat_out_valid", 64'(out_valid), 64'(k == STAGES));
        end
        drain();

        // Backpressure: 8 beats, output stalled for the first 5 cycles.
        n_acc  = 0;
        n_seen = 0;
        idx    = 0;
        for (int cyc = 0; cyc < 60 && n_seen < 8; cyc++) begin
            if (!pend && idx < 8) begin
                load_rand();
                idx++;
            end
            step(cyc >= 5, acc);
            if (acc) n_acc++;
            if (cyc == 4) begin
                check("bp_accepted", 64'(n_acc), 64'(STAGES));
                check("bp_in_ready_low", 64'(in_ready), 64'(0));
                check("bp_out_valid_held", 64'(out_valid), 64'(1));
            end
            if (cyc >= 5) begin
                check("bp_no_gap", 64'(out_valid), 64'(1));
                if (out_valid && out_ready) n_seen++;
            end
        end
        check("bp_all_out", 64'(n_seen), 64'(8));
        drain();

        // Back-to-back throughput with the output always ready.
        for (int i = 0; i < 20; i++) begin
            load_rand();
            step(1'b1, acc);
            check("tput_accept", 64'(acc), 64'(1));
            if (i >= STAGES) check("tput_out_valid", 64'(out_valid), 64'(1));
        end
        drain();

        // Reset with two beats in flight.
        load_rand(); send_pending(1'b0);
        load_rand(); send_pending(1'b0);
        step(1'b0, acc);
        check("rst_busy_before", 64'(busy), 64'(1));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_out_data", 64'(out_data), 64'(0));
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, acc);
            check("midrst_in_ready", 64'(in_ready), 64'(1));
            check("midrst_no_stale", 64'(out_valid), 64'(0));
        end

        // Random traffic with random valid and ready.
        n_acc = 0;
        for (int cyc = 0; cyc < 30000 && n_acc < 2000; cyc++) begin
            if (!pend && $urandom_range(0, 3) != 0) load_rand();
            step($urandom_range(0, 3) != 0, acc);
            if (acc) n_acc++;
        end
        check("rand_accepted", 64'(n_acc), 64'(2000));
        drain();
        check("final_busy", 64'(busy), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
